// File: rtl/lmc_pkg.sv
// Shared definitions for the LMC register-RAM arbiter.
// Widths, FSM state encoding and requester port IDs.
package lmc_pkg;

    localparam int LMC_AW = 2;
    localparam int LMC_DW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } lmc_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic logic other_port(input logic p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/lmc_rr_pick.sv
// Two-way winner select for the LMC RAM arbiter.
// Round-robin against the last grantee, or fixed A-first.
module lmc_rr_pick
    import lmc_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic a_req,
    input  logic b_req,
    input  logic owner,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = a_req | b_req;
        winner = owner;
        unique case (1'b1)
            (a_req && !b_req): winner = PORT_A;
            (b_req && !a_req): winner = PORT_B;
            (a_req && b_req): begin
                if (FIXED_PRIO != 0) begin
                    winner = PORT_A;
                end else begin
                    winner = other_port(owner);
                end
            end
            default: winner = owner;
        endcase
    end

endmodule

// File: rtl/lmc_ram_arbiter.sv
// Arbiter and access sequencer for the LMC 4x4 register RAM.
// Serialises loader (A) and CPU (B) single-word transactions.
module lmc_ram_arbiter
    import lmc_pkg::*;
#(
    parameter int AW         = LMC_AW,
    parameter int DW         = LMC_DW,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_adr,
    input  logic [DW-1:0] a_din,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_adr,
    input  logic [DW-1:0] b_din,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic          busy,
    output logic          owner
);

    lmc_state_e    state;
    lmc_state_e    state_d;
    logic [AW-1:0] adr_d;
    logic [DW-1:0] din_d;
    logic          we_d;
    logic          owner_d;
    logic          a_ack_d;
    logic          b_ack_d;
    logic [DW-1:0] a_rdata_d;
    logic [DW-1:0] b_rdata_d;
    logic          busy_d;
    logic          pick_valid;
    logic          pick_winner;

    lmc_rr_pick #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_pick (
        .a_req (a_req),
        .b_req (b_req),
        .owner (owner),
        .valid (pick_valid),
        .winner(pick_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ram_adr <= '0;
            ram_din <= '0;
            ram_we  <= 1'b0;
            owner   <= PORT_B;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            ram_adr <= adr_d;
            ram_din <= din_d;
            ram_we  <= we_d;
            owner   <= owner_d;
            a_ack   <= a_ack_d;
            b_ack   <= b_ack_d;
            a_rdata <= a_rdata_d;
            b_rdata <= b_rdata_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state;
        adr_d     = ram_adr;
        din_d     = ram_din;
        we_d      = ram_we;
        owner_d   = owner;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata;
        b_rdata_d = b_rdata;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    state_d = ACCESS;
                    if (pick_winner == PORT_A) begin
                        adr_d = a_adr;
                        din_d = a_din;
                        we_d  = a_we;
                    end else begin
                        adr_d = b_adr;
                        din_d = b_din;
                        we_d  = b_we;
                    end
                end
            end
            ACCESS: begin
                // ram_dout is sampled at the write edge: read-before-write
                we_d    = 1'b0;
                state_d = ACK;
                if (owner == PORT_A) begin
                    a_rdata_d = ram_dout;
                    a_ack_d   = 1'b1;
                end else begin
                    b_rdata_d = ram_dout;
                    b_ack_d   = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_lmc_ram_arbiter.sv
// Directed bench for lmc_ram_arbiter: a round-robin instance
// and a fixed-priority instance, each with its own 4x4 RAM.
module tb_lmc_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_req = 1'b0, a_we = 1'b0;
    logic [1:0] a_adr = '0;
    logic [3:0] a_din = '0;
    logic       b_req = 1'b0, b_we = 1'b0;
    logic [1:0] b_adr = '0;
    logic [3:0] b_din = '0;

    logic       a_ack_w [2];
    logic       b_ack_w [2];
    logic [3:0] a_rdata_w [2];
    logic [3:0] b_rdata_w [2];
    logic [1:0] ram_adr_w [2];
    logic [3:0] ram_din_w [2];
    logic       ram_we_w [2];
    logic [3:0] ram_dout_w [2];
    logic       busy_w [2];
    logic       owner_w [2];

    logic [3:0] mem [2][4] = '{default: '0};

    int tests = 0;
    int fails = 0;
    int a_ack_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_we_w[i]) mem[i][ram_adr_w[i]] <= ram_din_w[i];
        end
        if (a_ack_w[0]) a_ack_cnt <= a_ack_cnt + 1;
    end

    assign ram_dout_w[0] = mem[0][ram_adr_w[0]];
    assign ram_dout_w[1] = mem[1][ram_adr_w[1]];

    lmc_ram_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_din(a_din),
        .a_ack(a_ack_w[0]), .a_rdata(a_rdata_w[0]),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_din(b_din),
        .b_ack(b_ack_w[0]), .b_rdata(b_rdata_w[0]),
        .ram_adr(ram_adr_w[0]), .ram_din(ram_din_w[0]),
        .ram_we(ram_we_w[0]), .ram_dout(ram_dout_w[0]),
        .busy(busy_w[0]), .owner(owner_w[0])
    );

    lmc_ram_arbiter #(.FIXED_PRIO(1)) dut_fx (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_din(a_din),
        .a_ack(a_ack_w[1]), .a_rdata(a_rdata_w[1]),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_din(b_din),
        .b_ack(b_ack_w[1]), .b_rdata(b_rdata_w[1]),
        .ram_adr(ram_adr_w[1]), .ram_din(ram_din_w[1]),
        .ram_we(ram_we_w[1]), .ram_dout(ram_dout_w[1]),
        .busy(busy_w[1]), .owner(owner_w[1])
    );

    task automatic apply_reset();
        a_req = 1'b0;
        b_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_ack(input int d, output int cyc,
                            output logic ga, output logic gb);
        cyc = 0;
        ga = 1'b0;
        gb = 1'b0;
        for (int i = 0; i < 20 && !(ga || gb); i++) begin
            @(posedge clk); #1;
            cyc++;
            ga = a_ack_w[d];
            gb = b_ack_w[d];
        end
    endtask

    task automatic do_txn(input logic p, input logic we,
                          input logic [1:0] adr, input logic [3:0] din,
                          output int cyc, output logic [3:0] rd,
                          output logic ga, output logic gb);
        if (p) begin
            b_we = we; b_adr = adr; b_din = din; b_req = 1'b1;
        end else begin
            a_we = we; a_adr = adr; a_din = din; a_req = 1'b1;
        end
        wait_ack(0, cyc, ga, gb);
        rd = p ? b_rdata_w[0] : a_rdata_w[0];
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (ram_we_w[d] !== 1'b0 || ram_adr_w[d] !== 2'd0 ||
                ram_din_w[d] !== 4'd0 || busy_w[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_ram[%0d]: we=%b adr=%0d din=%h busy=%b, need 0",
                         d, ram_we_w[d], ram_adr_w[d], ram_din_w[d], busy_w[d]);
            end
            tests++;
            if (a_ack_w[d] !== 1'b0 || b_ack_w[d] !== 1'b0 ||
                a_rdata_w[d] !== 4'd0 || b_rdata_w[d] !== 4'd0) begin
                fails++;
                $display("FAIL reset_ack[%0d]: acks=%b%b rdata=%h/%h, need 0",
                         d, a_ack_w[d], b_ack_w[d], a_rdata_w[d], b_rdata_w[d]);
            end
            tests++;
            if (owner_w[d] !== 1'b1) begin
                fails++;
                $display("FAIL reset_owner[%0d]: got %b need 1", d, owner_w[d]);
            end
        end
    endtask

    task automatic test_a_write();
        int cyc;
        logic [3:0] rd;
        logic ga, gb;
        a_we = 1'b1; a_adr = 2'd0; a_din = 4'b0001; a_req = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (ram_we_w[0] !== 1'b1 || ram_adr_w[0] !== 2'd0 ||
            ram_din_w[0] !== 4'b0001 || busy_w[0] !== 1'b1 || owner_w[0] !== 1'b0) begin
            fails++;
            $display("FAIL a_write_access: we=%b adr=%0d din=%h busy=%b owner=%b, need 1 0 1 1 0",
                     ram_we_w[0], ram_adr_w[0], ram_din_w[0], busy_w[0], owner_w[0]);
        end
        wait_ack(0, cyc, ga, gb);
        tests++;
        if (!ga || gb || cyc + 1 != 2 || ram_we_w[0] !== 1'b0) begin
            fails++;
            $display("FAIL a_write_ack: ga=%b gb=%b lat=%0d we=%b, need 1 0 2 0",
                     ga, gb, cyc + 1, ram_we_w[0]);
        end
        a_req = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (a_ack_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
            fails++;
            $display("FAIL a_write_done: ack=%b busy=%b, need 0 0", a_ack_w[0], busy_w[0]);
        end
        do_txn(1'b0, 1'b0, 2'd0, 4'd0, cyc, rd, ga, gb);
        tests++;
        if (!ga || cyc != 2 || rd !== 4'b0001) begin
            fails++;
            $display("FAIL a_read_back: ga=%b lat=%0d rdata=%h, need 1 2 1", ga, cyc, rd);
        end
    endtask

    task automatic test_b_port();
        int cyc, cnt0;
        logic [3:0] rd;
        logic ga, gb;
        cnt0 = a_ack_cnt;
        do_txn(1'b1, 1'b1, 2'd1, 4'b0010, cyc, rd, ga, gb);
        tests++;
        if (!gb || ga || cyc != 2) begin
            fails++;
            $display("FAIL b_write_ack: ga=%b gb=%b lat=%0d, need 0 1 2", ga, gb, cyc);
        end
        do_txn(1'b1, 1'b0, 2'd1, 4'd0, cyc, rd, ga, gb);
        tests++;
        if (!gb || rd !== 4'b0010) begin
            fails++;
            $display("FAIL b_read_back: gb=%b rdata=%h, need 1 2", gb, rd);
        end
        tests++;
        if (a_ack_cnt != cnt0 || owner_w[0] !== 1'b1 || a_rdata_w[0] !== 4'b0001) begin
            fails++;
            $display("FAIL b_isolation: a_acks=%0d owner=%b a_rdata=%h, need 0 1 1",
                     a_ack_cnt - cnt0, owner_w[0], a_rdata_w[0]);
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        logic ga, gb;
        apply_reset();
        a_we = 1'b0; a_adr = 2'd0; a_req = 1'b1;
        b_we = 1'b0; b_adr = 2'd1; b_req = 1'b1;
        wait_ack(0, cyc, ga, gb);
        tests++;
        if (!ga || gb || cyc != 2 || owner_w[0] !== 1'b0 || a_rdata_w[0] !== 4'b0001) begin
            fails++;
            $display("FAIL rr_first: ga=%b gb=%b lat=%0d owner=%b rdata=%h, need 1 0 2 0 1",
                     ga, gb, cyc, owner_w[0], a_rdata_w[0]);
        end
        a_adr = 2'd1;
        wait_ack(0, cyc, ga, gb);
        tests++;
        if (ga || !gb || cyc != 3 || owner_w[0] !== 1'b1 || b_rdata_w[0] !== 4'b0010) begin
            fails++;
            $display("FAIL rr_second: ga=%b gb=%b lat=%0d owner=%b rdata=%h, need 0 1 3 1 2",
                     ga, gb, cyc, owner_w[0], b_rdata_w[0]);
        end
        b_req = 1'b0;
        wait_ack(0, cyc, ga, gb);
        tests++;
        if (!ga || gb || cyc != 3 || a_rdata_w[0] !== 4'b0010) begin
            fails++;
            $display("FAIL rr_third: ga=%b gb=%b lat=%0d rdata=%h, need 1 0 3 2",
                     ga, gb, cyc, a_rdata_w[0]);
        end
        a_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_prio();
        int cyc;
        logic ga, gb;
        apply_reset();
        a_we = 1'b0; a_adr = 2'd0; a_req = 1'b1;
        b_we = 1'b0; b_adr = 2'd1; b_req = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wait_ack(1, cyc, ga, gb);
            tests++;
            if (!ga || gb || cyc != (r == 0 ? 2 : 3)) begin
                fails++;
                $display("FAIL fixed_round%0d: ga=%b gb=%b lat=%0d, need 1 0 %0d",
                         r, ga, gb, cyc, (r == 0 ? 2 : 3));
            end
        end
        a_req = 1'b0;
        wait_ack(1, cyc, ga, gb);
        tests++;
        if (ga || !gb || cyc > 3 || b_rdata_w[1] !== 4'b0010) begin
            fails++;
            $display("FAIL fixed_b_after: ga=%b gb=%b lat=%0d rdata=%h, need 0 1 <=3 2",
                     ga, gb, cyc, b_rdata_w[1]);
        end
        b_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        int cyc, cnt0;
        logic [3:0] rd;
        logic ga, gb;
        apply_reset();
        cnt0 = a_ack_cnt;
        a_we = 1'b1; a_adr = 2'd2; a_din = 4'b1111; a_req = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (ram_we_w[0] !== 1'b1 || ram_adr_w[0] !== 2'd2) begin
            fails++;
            $display("FAIL mid_access_setup: we=%b adr=%0d, need 1 2", ram_we_w[0], ram_adr_w[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (ram_we_w[0] !== 1'b0 || ram_adr_w[0] !== 2'd0 || ram_din_w[0] !== 4'd0 ||
            busy_w[0] !== 1'b0 || a_ack_w[0] !== 1'b0 || owner_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL mid_access_rst: we=%b adr=%0d din=%h busy=%b ack=%b owner=%b, need 0 0 0 0 0 1",
                     ram_we_w[0], ram_adr_w[0], ram_din_w[0], busy_w[0], a_ack_w[0], owner_w[0]);
        end
        a_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (a_ack_cnt != cnt0) begin
            fails++;
            $display("FAIL mid_access_noack: a_acks=%0d need 0", a_ack_cnt - cnt0);
        end
        do_txn(1'b0, 1'b0, 2'd2, 4'd0, cyc, rd, ga, gb);
        tests++;
        if (!ga || rd !== 4'b0000) begin
            fails++;
            $display("FAIL mid_access_nowrite: ga=%b rdata=%h, need 1 0", ga, rd);
        end
    endtask

    task automatic test_read_before_write();
        int cyc;
        logic [3:0] rd;
        logic ga, gb;
        do_txn(1'b0, 1'b1, 2'd3, 4'b0100, cyc, rd, ga, gb);
        tests++;
        if (!ga || rd !== 4'b0000) begin
            fails++;
            $display("FAIL rbw_first: ga=%b rdata=%h, need 1 0", ga, rd);
        end
        do_txn(1'b0, 1'b1, 2'd3, 4'b1000, cyc, rd, ga, gb);
        tests++;
        if (!ga || rd !== 4'b0100) begin
            fails++;
            $display("FAIL rbw_old: ga=%b rdata=%h, need 1 4", ga, rd);
        end
        do_txn(1'b0, 1'b0, 2'd3, 4'd0, cyc, rd, ga, gb);
        tests++;
        if (!ga || rd !== 4'b1000) begin
            fails++;
            $display("FAIL rbw_new: ga=%b rdata=%h, need 1 8", ga, rd);
        end
    endtask

    initial begin
        test_reset();
        test_a_write();
        test_b_port();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid_access();
        test_read_before_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
